mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory port between the multicycle core (fetch/load/store) and the program
//  loader port. Round-robin on contention, one transaction at a time, waits on a variable-latency
//  memory with a timeout.
//  Sits between the datapath memory address mux (PC / ALU result) and the instruction/data memory.
// PARAMETERS
//  ADDR_W    32  address width, both requesters and memory
//  DATA_W    32  data width
//  TIMEOUT   15  max cycles in BUSY waiting for mem_ready before the transaction is aborted
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  core_req   in   1       core transaction request; held until core_ack
//  core_we    in   1       1 = write, 0 = read
//  core_addr  in   ADDR_W  core byte address
//  core_wdata in   DATA_W  core write data
//  core_rdata out  DATA_W  registered read data for core
//  core_ack   out  1       one-cycle completion pulse to core
//  core_err   out  1       one-cycle pulse with core_ack when the transaction timed out
//  ldr_req / ldr_we / ldr_addr / ldr_wdata / ldr_rdata / ldr_ack / ldr_err
//                          loader port; same widths and meaning as core_*
//  mem_req    out  1       memory request, registered
//  mem_we     out  1       memory write enable, registered
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched write data
//  mem_rdata  in   DATA_W  memory read data, valid when mem_ready=1
//  mem_ready  in   1       memory completion, sampled on clk
//  owner      out  1       0 = core, 1 = loader; owner of the current or most recent transaction
// BEHAVIOUR
//  - States: IDLE, BUSY, RESP.
//  - Reset values:
//    - state=IDLE.
//    - mem_req, mem_we, all ack and err outputs = 0.
//    - mem_addr, mem_wdata, core_rdata, ldr_rdata = 0.
//    - owner=1, so the core wins the first tie.
//    - Reset mid-transaction aborts with no ack; memory sees mem_req drop on the next cycle.
//  - IDLE, neither req: stay.
//  - IDLE, one req: grant that requester.
//  - IDLE, both req: grant the requester != owner (round-robin).
//  - On grant, at the same edge:
//    - latch we/addr/wdata of the granted requester into mem_we/mem_addr/mem_wdata;
//    - set owner, mem_req=1, timeout counter=0;
//    - go to BUSY.
//  - BUSY:
//    - mem_req held at 1; mem_addr, mem_we and mem_wdata are stable.
//    - Requester inputs are ignored.
//    - Counter increments each cycle with mem_ready=0.
//    - mem_ready=1: at that edge go to RESP and clear mem_req.
//      - On a read, capture mem_rdata into owner's rdata register.
//      - On a write, rdata is unchanged.
//    - mem_ready=0 with counter == TIMEOUT-1: go to RESP with err, mem_req=0, rdata unchanged.
//  - RESP:
//    - owner's ack=1 for exactly this cycle; err=1 too if timed out.
//    - Next state is IDLE unconditionally.
//  - Requester contract:
//    - drop req on the cycle after ack;
//    - req still high in the following IDLE cycle starts a new transaction;
//    - req dropped before grant is simply never served.
//  - Minimum latency:
//    - req high in cycle 0 -> mem_req in cycle 1;
//    - mem_ready=1 in cycle 1 -> ack in cycle 2 -> IDLE in cycle 3.
//  - Non-owner ack and err stay 0. Both acks are never high together.
//  - Timeout counter width is $clog2(TIMEOUT+1); it never wraps.
// TESTING
//  1. Core read, addr=0x10, mem_ready one cycle after mem_req, mem_rdata=0xDEADBEEF
//     -> core_ack in cycle 2, core_rdata=0xDEADBEEF, ldr_ack=0.
//  2. core_req and ldr_req both high from reset release, 4 back-to-back transactions
//     -> grant order core, ldr, core, ldr; owner toggles.
//  3. Loader write addr=0x40, wdata=0x12345678, mem_ready delayed 5 cycles
//     -> mem_addr/mem_wdata/mem_we stable for all 6 BUSY cycles; single ldr_ack; ldr_rdata unchanged.
//  4. mem_ready held 0 -> core_ack and core_err pulse after exactly TIMEOUT BUSY cycles;
//     mem_req falls at the same edge.
//  5. reset asserted in the 2nd BUSY cycle -> next cycle mem_req=0, no ack, outputs at reset values;
//     a new core_req is served normally.
//  6. core_req held high across its ack -> exactly one IDLE cycle, then a second transaction;
//     rdata updated twice.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: round-robin share of one memory port between core and loader, |
// | one transaction at a time, with a mem_ready timeout.   Rev 1.0             |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_err,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              ldr_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              owner
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_grant_ldr;

  // Loader wins when it is alone, or on a tie when the core held the port last.
  always_comb begin
    w_grant_ldr = ldr_req && (!core_req || !owner);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      ldr_rdata  <= '0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
      owner      <= 1'b1;
    end else begin
      core_ack <= 1'b0;
      core_err <= 1'b0;
      ldr_ack  <= 1'b0;
      ldr_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (core_req || ldr_req) begin
            owner     <= w_grant_ldr;
            mem_we    <= w_grant_ldr ? ldr_we    : core_we;
            mem_addr  <= w_grant_ldr ? ldr_addr  : core_addr;
            mem_wdata <= w_grant_ldr ? ldr_wdata : core_wdata;
            mem_req   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            r_state  <= ST_RESP;
            core_ack <= !owner;
            ldr_ack  <= owner;
            if (!mem_we) begin
              if (owner) ldr_rdata  <= mem_rdata;
              else       core_rdata <= mem_rdata;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            mem_req  <= 1'b0;
            r_state  <= ST_RESP;
            core_ack <= !owner;
            ldr_ack  <= owner;
            core_err <= !owner;
            ldr_err  <= owner;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: directed and randomized transactions against a            |
// | transaction-level model of the arbiter.   Rev 1.0                           |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, ldr_req, ldr_we, mem_ready;
  logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata, mem_rdata;
  logic [31:0] core_rdata, ldr_rdata, mem_addr, mem_wdata;
  logic        core_ack, core_err, ldr_ack, ldr_err, mem_req, mem_we, owner;

  int tests = 0;
  int fails = 0;

  // Model state: who held the port last and what each requester last read.
  logic        last_owner;
  logic [31:0] exp_core_rdata, exp_ldr_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
    .core_err(core_err),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .ldr_err(ldr_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_core_rdata"}, core_rdata, 32'd0);
    chk({tag, "_ldr_rdata"}, ldr_rdata, 32'd0);
    chk({tag, "_acks_errs"}, {28'd0, core_ack, core_err, ldr_ack, ldr_err}, 32'd0);
    chk({tag, "_owner"}, {31'd0, owner}, 32'd1);
  endtask

  // One full transaction. lat = number of BUSY cycles with mem_ready low before
  // it rises; lat >= TIMEOUT means the memory never answers.
  task automatic txn(input logic c, input logic l, input logic cwe, input logic lwe,
                     input logic [31:0] ca, input logic [31:0] la,
                     input logic [31:0] cwd, input logic [31:0] lwd,
                     input int lat, input logic hold);
    logic        eo, ewe, to;
    logic [31:0] ea, ed, rd;
    int          waits;
    to  = (lat >= TIMEOUT);
    eo  = (c && l) ? ~last_owner : l;
    ewe = eo ? lwe : cwe;
    ea  = eo ? la : ca;
    ed  = eo ? lwd : cwd;
    core_req = c; ldr_req = l; core_we = cwe; ldr_we = lwe;
    core_addr = ca; ldr_addr = la; core_wdata = cwd; ldr_wdata = lwd;
    mem_ready = 1'b0;
    step();
    chk("grant_mem_req", {31'd0, mem_req}, 32'd1);
    chk("grant_owner", {31'd0, owner}, {31'd0, eo});
    chk("grant_addr", mem_addr, ea);
    chk("grant_we", {31'd0, mem_we}, {31'd0, ewe});
    chk("grant_wdata", mem_wdata, ed);
    last_owner = eo;
    rd = $urandom;
    waits = to ? TIMEOUT - 1 : lat;
    for (int k = 0; k < waits; k++) begin
      core_addr = $urandom; ldr_addr = $urandom;
      core_wdata = $urandom; ldr_wdata = $urandom;
      core_we = ~cwe; ldr_we = ~lwe;
      step();
      chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
      chk("busy_addr", mem_addr, ea);
      chk("busy_wdata", mem_wdata, ed);
      chk("busy_we", {31'd0, mem_we}, {31'd0, ewe});
      chk("busy_acks", {30'd0, core_ack, ldr_ack}, 32'd0);
    end
    core_we = cwe; ldr_we = lwe; core_addr = ca; ldr_addr = la;
    core_wdata = cwd; ldr_wdata = lwd;
    mem_ready = ~to;
    mem_rdata = rd;
    step();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (!to && !ewe) begin
      if (eo) exp_ldr_rdata = rd;
      else    exp_core_rdata = rd;
    end
    chk("resp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("resp_core_ack", {31'd0, core_ack}, {31'd0, ~eo});
    chk("resp_ldr_ack", {31'd0, ldr_ack}, {31'd0, eo});
    chk("resp_core_err", {31'd0, core_err}, {31'd0, ~eo & to});
    chk("resp_ldr_err", {31'd0, ldr_err}, {31'd0, eo & to});
    chk("resp_core_rdata", core_rdata, exp_core_rdata);
    chk("resp_ldr_rdata", ldr_rdata, exp_ldr_rdata);
    if (!hold) begin
      core_req = 1'b0;
      ldr_req  = 1'b0;
    end
    step();
    chk("idle_acks_errs", {28'd0, core_ack, core_err, ldr_ack, ldr_err}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic model_reset();
    last_owner     = 1'b1;
    exp_core_rdata = 32'd0;
    exp_ldr_rdata  = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    model_reset();
    step(); step();
    chk_reset_state("reset");

    // Both requesters high from reset release, held across acks: core, ldr, core, ldr.
    core_req = 1'b1; ldr_req = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      txn(1, 1, 0, 0, 32'h100 + i, 32'h200 + i, 0, 0, i, (i < 3));

    // Core read with single-cycle memory.
    txn(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0);
    txn(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0);

    // Loader write, memory answers after 5 waits.
    txn(0, 1, 0, 1, 32'h0, 32'h40, 32'h0, 32'h12345678, 5, 0);

    // Timeout on core; then the latest possible on-time answer.
    txn(1, 0, 0, 0, 32'h80, 32'h0, 32'h0, 32'h0, TIMEOUT, 0);
    txn(0, 1, 0, 0, 32'h0, 32'h84, 32'h0, 32'h0, TIMEOUT - 1, 0);

    // Core request held across ack: two back-to-back reads.
    txn(1, 0, 0, 0, 32'h90, 32'h0, 32'h0, 32'h0, 1, 1);
    txn(1, 0, 0, 0, 32'h90, 32'h0, 32'h0, 32'h0, 0, 0);

    // Reset in the second BUSY cycle.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'hA0;
    step();
    chk("rst_busy_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    reset = 1'b1;
    core_req = 1'b0;
    step();
    chk_reset_state("rst_mid");
    reset = 1'b0;
    model_reset();
    step();
    chk("rst_after_acks", {30'd0, core_ack, ldr_ack}, 32'd0);
    txn(1, 0, 0, 0, 32'hA4, 32'h0, 32'h0, 32'h0, 2, 0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      int pat, lat;
      pat = $urandom_range(1, 3);
      lat = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 6);
      txn(pat[0], pat[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
          $urandom, $urandom, lat, 1'($urandom_range(0, 1)) & pat[0] & pat[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
